miter_sequencer: RTL

//  Synthesizable successor to the simulation-only GM/FM miter loop. Reads operand pairs from an

---
 rtl/miter_pkg.sv | 14 +
 rtl/miter_settle_cnt.sv | 38 +++
 rtl/miter_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/miter_pkg.sv
// Shared types for the GM/FM miter sequencer: FSM state encoding.
package miter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_B = 3'd2,
        APPLY   = 3'd3,
        SETTLE  = 3'd4,
        EMIT    = 3'd5,
        DONE    = 3'd6
    } state_e;

endpackage

// File: rtl/miter_settle_cnt.sv
// Settle timer: loaded when operands are applied, flags expiry after LATENCY cycles in SETTLE.
// Latency: expired_o is registered; backpressure: none (counter only counts when en_i).
module miter_settle_cnt #(
    parameter int LATENCY = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // Holding LATENCY-1 on entry gives exactly LATENCY cycles spent in SETTLE.
    localparam logic [CW-1:0] LOAD_VAL = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/miter_sequencer.sv
// Fetches operand pairs, drives both CUT copies, compares GM/FM results and streams records.
// Latency 4+CUT_LATENCY cycles per vector; record held stable while rec_ready_i is low.
module miter_sequencer
    import miter_pkg::*;
#(
    parameter int OPERAND_PRECISION = 16,
    parameter int RESULT_PRECISION  = 32,
    parameter int TOTAL_OPERS       = 1024,
    parameter int CUT_LATENCY       = 0,
    parameter int ADDR_W            = $clog2(TOTAL_OPERS),
    parameter int CNT_W             = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start_i,
    input  logic                         stop_on_mismatch_i,
    output logic                         mem_rd_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    input  logic [OPERAND_PRECISION-1:0] mem_data_i,
    output logic [OPERAND_PRECISION-1:0] operand_a_o,
    output logic [OPERAND_PRECISION-1:0] operand_b_o,
    input  logic [RESULT_PRECISION-1:0]  gm_result_i,
    input  logic [RESULT_PRECISION-1:0]  fm_result_i,
    output logic                         rec_valid_o,
    input  logic                         rec_ready_i,
    output logic [ADDR_W-1:0]            rec_index_o,
    output logic [RESULT_PRECISION-1:0]  rec_golden_o,
    output logic [RESULT_PRECISION-1:0]  rec_computed_o,
    output logic                         rec_mismatch_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [CNT_W-1:0]             mismatch_count_o,
    output logic [ADDR_W-1:0]            first_mm_idx_o
);

    localparam int NVEC = TOTAL_OPERS / 2;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NVEC - 1);

    if (TOTAL_OPERS % 2 != 0) begin : g_odd_opers
        $error("miter_sequencer: TOTAL_OPERS must be even");
    end

    typedef struct packed {
        logic [ADDR_W-1:0]           index;
        logic [RESULT_PRECISION-1:0] golden;
        logic [RESULT_PRECISION-1:0] computed;
        logic                        mismatch;
    } miter_rec_t;

    state_e                         state_q, state_d;
    logic [ADDR_W-1:0]              idx_q, idx_d;
    logic [OPERAND_PRECISION-1:0]   op_a_q, op_a_d;
    logic [OPERAND_PRECISION-1:0]   op_b_q, op_b_d;
    miter_rec_t                     rec_q, rec_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic [ADDR_W-1:0]              first_mm_q, first_mm_d;
    logic                           settle_load;
    logic                           settle_expired;
    logic                           sample;

    miter_settle_cnt #(
        .LATENCY (CUT_LATENCY)
    ) u_settle_cnt (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_i    (settle_load),
        .en_i      (state_q == SETTLE),
        .expired_o (settle_expired)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rec_d       = rec_q;
        count_d     = count_q;
        first_mm_d  = first_mm_q;
        mem_rd_o    = 1'b0;
        mem_addr_o  = '0;
        settle_load = 1'b0;
        sample      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = FETCH_A;
                    idx_d      = '0;
                    count_d    = '0;
                    first_mm_d = '0;
                end
            end
            FETCH_A: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = idx_q << 1;
                state_d    = FETCH_B;
            end
            FETCH_B: begin
                op_a_d     = mem_data_i;
                mem_rd_o   = 1'b1;
                mem_addr_o = (idx_q << 1) | ADDR_W'(1);
                state_d    = APPLY;
            end
            APPLY: begin
                // b goes to the CUT straight from the memory this cycle, so a
                // combinational CUT can be sampled at the end of APPLY.
                op_b_d      = mem_data_i;
                settle_load = 1'b1;
                if (CUT_LATENCY == 0) begin
                    sample  = 1'b1;
                    state_d = EMIT;
                end else begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_expired) begin
                    sample  = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rec_ready_i) begin
                    if (rec_q.mismatch) begin
                        if (count_q == '0) begin
                            first_mm_d = rec_q.index;
                        end
                        if (count_q != '1) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                    if ((idx_q == LAST_IDX) || (stop_on_mismatch_i && rec_q.mismatch)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = FETCH_A;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (sample) begin
            rec_d.index    = idx_q;
            rec_d.golden   = gm_result_i;
            rec_d.computed = fm_result_i;
            // Case inequality so an X/Z on either result reads as a mismatch.
            rec_d.mismatch = (gm_result_i !== fm_result_i);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            rec_q      <= '0;
            count_q    <= '0;
            first_mm_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            rec_q      <= rec_d;
            count_q    <= count_d;
            first_mm_q <= first_mm_d;
        end
    end

    assign operand_a_o      = op_a_q;
    assign operand_b_o      = (state_q == APPLY) ? mem_data_i : op_b_q;
    assign rec_valid_o      = (state_q == EMIT);
    assign rec_index_o      = rec_q.index;
    assign rec_golden_o     = rec_q.golden;
    assign rec_computed_o   = rec_q.computed;
    assign rec_mismatch_o   = rec_q.mismatch;
    assign busy_o           = (state_q != IDLE) && (state_q != DONE);
    assign done_o           = (state_q == DONE);
    assign mismatch_count_o = count_q;
    assign first_mm_idx_o   = first_mm_q;

endmodule
